bit_serializer: RTL
===================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits per parallel word (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: din  input  WIDTH  parallel word to serialize.
REQ-005 Port: din_valid  input  1  din holds a word to be accepted.
REQ-006 Port: din_ready  output  1  block accepts din this cycle.
REQ-007 Port: sout  output  1  serial bit stream; feeds the sequence detector's in port directly.
REQ-008 Port: sout_valid  output  1  sout carries a payload or parity bit this cycle.
REQ-009 Port: busy  output  1  a word is currently being shifted.

Function
REQ-010 Handshake: a word SHALL be accepted on a rising edge where din_valid and din_ready are both 1; no other edge accepts.
REQ-011 States SHALL be IDLE, SHIFT and, only with PARITY_EN, PAR.
REQ-012 IDLE: din_ready=1, sout=0, sout_valid=0, busy=0; an accepted word moves to SHIFT.
REQ-013 SHIFT: word SHALL be sent MSB first, one bit per cycle, for exactly WIDTH cycles; first bit appears on sout in the cycle after the accepting edge (latency 1).
REQ-014 A bit counter of $clog2(WIDTH) bits SHALL count 0..WIDTH-1 with no wrap beyond WIDTH-1.
REQ-015 sout_valid=1 and busy=1 for every SHIFT and PAR cycle.
REQ-016 din_ready SHALL be combinational from state: 1 in IDLE, 1 in the last stream cycle of a word (last SHIFT cycle without parity, PAR cycle with parity), otherwise 0.
REQ-017 Acceptance in the last stream cycle SHALL start the next word's MSB in the following cycle with no gap (back-to-back words form a contiguous stream, so patterns spanning a word boundary remain detectable downstream).
REQ-018 No acceptance in the last stream cycle SHALL return to IDLE.
REQ-019 din SHALL be captured into an internal shift register at acceptance; later din changes have no effect on the word in flight.
REQ-020 din_valid while din_ready=0 SHALL be ignored; the source holds it.

Reset
REQ-021 rst=1 at a rising edge SHALL force IDLE, counter=0, shift register=0, sout=0, sout_valid=0, busy=0, regardless of state.
REQ-022 Reset mid-word SHALL discard the word; no further bits of it appear; din_ready=1 in the cycle after reset deasserts.
REQ-023 rst SHALL dominate a simultaneous din_valid&&din_ready; that word is not accepted.

Configuration
REQ-024 Macro PARITY_EN: defined -> after the WIDTH payload bits, one PAR cycle drives the even-parity bit (XOR of all WIDTH bits) on sout, stream length WIDTH+1 per word; undefined -> no PAR state, stream length WIDTH, no parity logic present.

Structure
REQ-025 Package bit_serializer_pkg SHALL hold the state enum type (IDLE, SHIFT, PAR) and the default WIDTH constant.
REQ-026 The design SHALL be a single module; no sub-module.

Verification (WIDTH=8)
REQ-027 Accept 8'b0110_1101 from IDLE -> sout over next 8 cycles 0,1,1,0,1,1,0,1; sout_valid=1 those cycles; din_ready=0 in first 7, 1 in 8th.
REQ-028 Words 8'hA5 then 8'h3C, din_valid held -> 16 contiguous valid bits 1010_0101_0011_1100, sout_valid never drops between words.
REQ-029 rst pulsed during the 4th bit of 8'hFF -> sout=0, sout_valid=0, busy=0 next cycle; din_ready=1 after rst deasserts; remaining bits never appear.
REQ-030 din_valid=0 for 20 cycles after reset -> sout=0, sout_valid=0, din_ready=1 throughout.
REQ-031 PARITY_EN defined, accept 8'h07 -> 8 payload bits 0000_0111 then parity bit 1 in 9th cycle; 8'h03 -> parity bit 0.
REQ-032 Serializer driving the sequence detector with 8'b0110_1100 -> detector out asserts at the cycle its target pattern completes, matching a direct bit-stimulus run.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the bit serializer: FSM state encoding and default word width.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter, MSB first, with back-to-back word chaining.
// Define PARITY_EN to append one even-parity bit after each word's payload.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   shreg_d;
    logic               sout_q;
    logic               sout_valid_q;
    logic               busy_q;
    logic               last_bit;
    logic               accept;
`ifdef PARITY_EN
    logic               par_q;
`endif

    assign last_bit = (cnt_q == CNT_LAST);
    assign accept   = din_valid && din_ready;
    assign shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};

    // Ready in the final stream cycle lets the next word follow with no idle gap.
    always_comb begin
        din_ready = 1'b0;
        case (state_q)
            IDLE:    din_ready = 1'b1;
`ifdef PARITY_EN
            SHIFT:   din_ready = 1'b0;
            PAR:     din_ready = 1'b1;
`else
            SHIFT:   din_ready = last_bit;
`endif
            default: din_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef PARITY_EN
            par_q        <= 1'b0;
`endif
        end else if (accept) begin
            // The MSB goes straight to the output register; the rest waits in shreg_q.
            state_q      <= SHIFT;
            cnt_q        <= '0;
            shreg_q      <= {din[WIDTH-2:0], 1'b0};
            sout_q       <= din[WIDTH-1];
            sout_valid_q <= 1'b1;
            busy_q       <= 1'b1;
`ifdef PARITY_EN
            par_q        <= ^din;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (last_bit) begin
`ifdef PARITY_EN
                        state_q <= PAR;
                        sout_q  <= par_q;
`else
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                        sout_q       <= 1'b0;
                        sout_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
`endif
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        sout_q  <= shreg_q[WIDTH-1];
                        shreg_q <= shreg_d;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    cnt_q        <= '0;
                    sout_q       <= 1'b0;
                    sout_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;

endmodule
